// File: rtl/opfetch_pkg.sv
// Shared decode constants for the operand-fetch stage and the ALU it feeds.
package opfetch_pkg;

  localparam int unsigned NumRegs  = 8;
  localparam int unsigned DataW    = 16;
  localparam int unsigned RegAddrW = 3;
  localparam int unsigned Imm7W    = 7;

  // Instruction field positions (LSB of each field)
  localparam int unsigned OpcodeLsb = 13;
  localparam int unsigned OpcodeW   = 3;
  localparam int unsigned RdLsb     = 10;
  localparam int unsigned RsLsb     = 7;
  localparam int unsigned RtLsb     = 4;
  localparam int unsigned ImmLsb    = 0;

  typedef enum logic [2:0] {
    OpAdd  = 3'b000,
    OpSub  = 3'b001,
    OpAnd  = 3'b010,
    OpOr   = 3'b011,
    OpAddi = 3'b100,
    OpNop  = 3'b101,
    OpIll0 = 3'b110,
    OpIll1 = 3'b111
  } opcode_e;

  // Encoding shared with the ALU
  typedef enum logic [1:0] {
    AluAdd = 2'b00,
    AluSub = 2'b01,
    AluAnd = 2'b10,
    AluOr  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/regfile_8x16.sv
// Register file: two combinational read ports with write-through, one write port, r0 hardwired 0.
module regfile_8x16
  import opfetch_pkg::*;
#(
  parameter int unsigned NREGS = NumRegs,
  parameter int unsigned DW    = DataW,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i
);

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];

  // Next state: write port; writes to r0 are dropped
  always_comb begin
    regs_d = regs_q;
    if (we_i && (waddr_i != '0)) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  // Storage with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: same-cycle write data bypasses storage; r0 always reads 0
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    rdata_b_o = regs_q[raddr_b_i];
    if (we_i && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (we_i && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
    if (raddr_a_i == '0) rdata_a_o = '0;
    if (raddr_b_i == '0) rdata_b_o = '0;
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode and operand fetch: scoreboard interlock, regfile read, registered ALU operands.
module operand_fetch
  import opfetch_pkg::*;
#(
  parameter int unsigned NREGS = NumRegs,
  parameter int unsigned DW    = DataW,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [15:0]   in_instr,
  output logic          in_ready,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [1:0]    alu_op,
  output logic [AW-1:0] out_rd,
  output logic          illegal
);

  opcode_e            opcode;
  logic [AW-1:0]      rd, rs, rt;
  logic [Imm7W-1:0]   imm7;
  logic               is_alu, is_rtype, is_illegal;
  alu_op_e            alu_op_dec;
  logic [NREGS-1:0]   busy_q, busy_d, wb_clr, busy_eff;
  logic               hazard, accept, issue;
  logic [DW-1:0]      rdata_a, rdata_b, opnd_b;
  logic [DW-1:0]      a_q, a_d, b_q, b_d;
  alu_op_e            alu_op_q, alu_op_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic               out_valid_q, out_valid_d, illegal_q, illegal_d;

  assign opcode = opcode_e'(in_instr[OpcodeLsb +: OpcodeW]);
  assign rd     = in_instr[RdLsb +: AW];
  assign rs     = in_instr[RsLsb +: AW];
  assign rt     = in_instr[RtLsb +: AW];
  assign imm7   = in_instr[ImmLsb +: Imm7W];

  // Opcode decode
  always_comb begin
    is_alu     = 1'b0;
    is_rtype   = 1'b0;
    is_illegal = 1'b0;
    alu_op_dec = AluAdd;
    unique case (opcode)
      OpAdd:  begin is_alu = 1'b1; is_rtype = 1'b1; alu_op_dec = AluAdd; end
      OpSub:  begin is_alu = 1'b1; is_rtype = 1'b1; alu_op_dec = AluSub; end
      OpAnd:  begin is_alu = 1'b1; is_rtype = 1'b1; alu_op_dec = AluAnd; end
      OpOr:   begin is_alu = 1'b1; is_rtype = 1'b1; alu_op_dec = AluOr;  end
      OpAddi: begin is_alu = 1'b1; alu_op_dec = AluAdd; end
      OpNop:  ;
      default: is_illegal = 1'b1;
    endcase
  end

  // A writeback landing this cycle releases its register immediately
  assign wb_clr   = wb_en ? (NREGS'(1) << wb_addr) : '0;
  assign busy_eff = busy_q & ~wb_clr;

  // Hazard depends only on instruction, scoreboard and writeback; flush stays out of it
  always_comb begin
    hazard = is_alu && (busy_eff[rs] || busy_eff[rd] || (is_rtype && busy_eff[rt]));
  end

  assign in_ready = !hazard;
  assign accept   = in_valid && in_ready;
  assign issue    = accept && !flush && is_alu;

  regfile_8x16 #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data)
  );

  assign opnd_b = is_rtype ? rdata_b : {{(DW - Imm7W){imm7[Imm7W-1]}}, imm7};

  // Next state: scoreboard (issue wins over a same-cycle clear) and output registers
  always_comb begin
    busy_d = busy_eff;
    if (issue && (rd != '0)) busy_d[rd] = 1'b1;
    busy_d[0]   = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    out_valid_d = issue;
    illegal_d   = accept && !flush && is_illegal;
    if (issue) begin
      a_d      = rdata_a;
      b_d      = opnd_b;
      alu_op_d = alu_op_dec;
      rd_d     = rd;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_op_q    <= AluAdd;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign alu_op    = alu_op_q;
  assign out_rd    = rd_q;
  assign illegal   = illegal_q;

endmodule
